conv_mac_seq: RTL

Sequenced, parametrised integer multiply-accumulate engine for one K×K convolution window. It accepts packed multiplier and multiplicand windows and time-multiplexes the K·K products over a configurable number of multiplier lanes. The block accumulates with optional saturation and cross-window chaining, and returns the result over a valid/ready handshake. It sits between the window/line-buffer feeder and the output writeback, and is the generalised successor of the fixed 8-bit, 3×3, single-shot convolution wrapper.

---
 rtl/conv_mac_seq.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/conv_mac_seq.sv
// conv_mac_seq: K x K window multiply-accumulate, time-multiplexed over LANES
// multipliers, with saturate/wrap accumulation, chaining and a valid/ready result.
module conv_mac_seq #(
    parameter int DATA_WIDTH  = 8,
    parameter int KERNEL_SIZE = 3,
    parameter int LANES       = 3,
    parameter int ACC_WIDTH   = 32,
    parameter bit SIGNED      = 1'b1,
    parameter bit SATURATE    = 1'b1
) (
    input  logic                                          Clk,
    input  logic                                          Rst,
    input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] multiplier_input,
    input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] multiplicand_input,
    input  logic                                          start,
    input  logic                                          chain,
    output logic                                          start_ready,
    output logic                                          busy,
    output logic [ACC_WIDTH-1:0]                          acc_out,
    output logic                                          acc_valid,
    input  logic                                          acc_ready,
    output logic                                          overflow
);
    localparam int KK = KERNEL_SIZE * KERNEL_SIZE;
    localparam int NG = (KK + LANES - 1) / LANES;
    localparam int PW = 2 * DATA_WIDTH;
    localparam int SW = ACC_WIDTH + $clog2(LANES) + 1;
    localparam int GW = (NG > 1) ? $clog2(NG) : 1;
    localparam int WW = NG * LANES * DATA_WIDTH;
    localparam logic [GW-1:0] LAST_G = GW'(NG - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t                   r_state;
    state_t                   w_next;
    logic                     w_start_ready;
    logic                     w_accept;
    logic [WW-1:0]            r_win_a;
    logic [WW-1:0]            r_win_b;
    logic [GW-1:0]            r_grp;
    logic [LANES-1:0][PW-1:0] r_prod;
    logic [LANES-1:0][PW-1:0] w_prod;
    logic                     r_pvalid;
    logic [ACC_WIDTH-1:0]     r_acc;
    logic [ACC_WIDTH-1:0]     w_acc_next;
    logic [ACC_WIDTH-1:0]     w_sat;
    logic                     r_ovf;
    logic                     w_ovf;
    logic [SW-1:0]            w_sum;
    logic [SW-ACC_WIDTH:0]    w_top_s;
    logic [SW-ACC_WIDTH-1:0]  w_top_u;

    // Operands are widened with their sign (or zero) so a plain
    // PW x PW product yields the correct low PW bits in both modes.
    function automatic logic [PW-1:0] mul(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        logic [PW-1:0] ax;
        logic [PW-1:0] bx;
        ax = {{DATA_WIDTH{SIGNED & a[DATA_WIDTH-1]}}, a};
        bx = {{DATA_WIDTH{SIGNED & b[DATA_WIDTH-1]}}, b};
        return ax * bx;
    endfunction

    function automatic logic [SW-1:0] ext_acc(input logic [ACC_WIDTH-1:0] x);
        return {{(SW - ACC_WIDTH){SIGNED & x[ACC_WIDTH-1]}}, x};
    endfunction

    function automatic logic [SW-1:0] ext_prod(input logic [PW-1:0] x);
        return {{(SW - PW){SIGNED & x[PW-1]}}, x};
    endfunction

    always_comb begin
        w_next        = r_state;
        w_start_ready = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_start_ready = 1'b1;
                if (start) w_next = S_MAC;
            end
            S_MAC: begin
                if (r_grp == LAST_G) w_next = S_FLUSH;
            end
            S_FLUSH: begin
                w_next = S_DONE;
            end
            S_DONE: begin
                w_start_ready = acc_ready;
                if (acc_ready) w_next = start ? S_MAC : S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign w_accept    = start && w_start_ready;
    assign start_ready = w_start_ready;
    assign busy        = (r_state == S_MAC) || (r_state == S_FLUSH);
    assign acc_valid   = (r_state == S_DONE);
    assign acc_out     = r_acc;
    assign overflow    = r_ovf;

    // Windows are zero-padded to NG*LANES elements, so tail lanes multiply 0.
    always_comb begin
        w_prod = '0;
        for (int l = 0; l < LANES; l++) begin
            w_prod[l] = mul(
                r_win_a[(int'(r_grp) * LANES + l) * DATA_WIDTH +: DATA_WIDTH],
                r_win_b[(int'(r_grp) * LANES + l) * DATA_WIDTH +: DATA_WIDTH]);
        end
    end

    always_comb begin
        w_sum = ext_acc(r_acc);
        for (int l = 0; l < LANES; l++) begin
            w_sum = w_sum + ext_prod(r_prod[l]);
        end
    end

    assign w_top_s = w_sum[SW-1:ACC_WIDTH-1];
    assign w_top_u = w_sum[SW-1:ACC_WIDTH];

    always_comb begin
        w_ovf = 1'b0;
        w_sat = '1;
        if (SIGNED) begin
            w_ovf = !((&w_top_s) || !(|w_top_s));
            w_sat = w_sum[SW-1] ? {1'b1, {(ACC_WIDTH - 1){1'b0}}}
                                : {1'b0, {(ACC_WIDTH - 1){1'b1}}};
        end else begin
            w_ovf = |w_top_u;
        end
        w_acc_next = (SATURATE && w_ovf) ? w_sat : w_sum[ACC_WIDTH-1:0];
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_win_a  <= '0;
            r_win_b  <= '0;
            r_grp    <= '0;
            r_prod   <= '0;
            r_pvalid <= 1'b0;
            r_acc    <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_pvalid <= (r_state == S_MAC);
            if (r_state == S_MAC) begin
                r_prod <= w_prod;
                r_grp  <= (r_grp == LAST_G) ? '0 : r_grp + GW'(1);
            end
            // Accept only happens in IDLE/DONE, when the product stage is empty.
            if (w_accept) begin
                r_win_a <= WW'(multiplier_input);
                r_win_b <= WW'(multiplicand_input);
                r_grp   <= '0;
                if (!chain) begin
                    r_acc <= '0;
                    r_ovf <= 1'b0;
                end
            end else if (r_pvalid) begin
                r_acc <= w_acc_next;
                r_ovf <= r_ovf | w_ovf;
            end
        end
    end
endmodule
